// File: rtl/hazard_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_unit_pkg
// Description : Shared hazard-unit types and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_unit_pkg;

    typedef enum logic [0:0] {
        HZ_IDLE = 1'b0,
        HZ_HOLD = 1'b1
    } hz_state_t;

    localparam int REG_ZERO   = 0;
    localparam int DEF_REG_AW = 5;

    // Stall request: 0..3 cycles
    typedef logic [1:0] stall_req_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_unit_if
// Description : ID/EX/MEM hazard fields and pipeline control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] rs_id;
    logic [REG_AW-1:0] rt_id;
    logic              use_rs_id;
    logic              use_rt_id;
    logic              branch_id;
    logic              branch_taken_id;
    logic [REG_AW-1:0] dst_ex;
    logic              regwrite_ex;
    logic              memread_ex;
    logic [REG_AW-1:0] dst_mem;
    logic              memread_mem;
    logic              ext_stall;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_noop;
    logic              ifid_flush;
    logic              stall_active;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output rs_id, rt_id, use_rs_id, use_rt_id, branch_id, branch_taken_id,
               dst_ex, regwrite_ex, memread_ex, dst_mem, memread_mem, ext_stall,
        input  pc_write, ifid_write, idex_noop, ifid_flush, stall_active, stall_cnt
    );

    modport slave (
        input  rs_id, rt_id, use_rs_id, use_rt_id, branch_id, branch_taken_id,
               dst_ex, regwrite_ex, memread_ex, dst_mem, memread_mem, ext_stall,
        output pc_write, ifid_write, idex_noop, ifid_flush, stall_active, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_unit_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_match
// Description : Combinational stall-count requirement from ID/EX/MEM fields.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_match
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_AW       = DEF_REG_AW,
    parameter int LD_BR_STALLS = 2
) (
    input  wire logic [REG_AW-1:0] rs_id,
    input  wire logic [REG_AW-1:0] rt_id,
    input  wire logic              use_rs_id,
    input  wire logic              use_rt_id,
    input  wire logic              branch_id,
    input  wire logic [REG_AW-1:0] dst_ex,
    input  wire logic              regwrite_ex,
    input  wire logic              memread_ex,
    input  wire logic [REG_AW-1:0] dst_mem,
    input  wire logic              memread_mem,
    output stall_req_t             n_req
);

    localparam logic [REG_AW-1:0] c_zero   = REG_AW'(REG_ZERO);
    localparam stall_req_t        c_ld_br  = stall_req_t'(LD_BR_STALLS);

    logic w_ex_hit;
    logic w_mem_hit;

    always_comb begin
        w_ex_hit  = ((use_rs_id && (rs_id == dst_ex) && (rs_id != c_zero)) ||
                     (use_rt_id && (rt_id == dst_ex) && (rt_id != c_zero))) && regwrite_ex;
        w_mem_hit = ((use_rs_id && (rs_id == dst_mem) && (rs_id != c_zero)) ||
                     (use_rt_id && (rt_id == dst_mem) && (rt_id != c_zero))) && memread_mem;

        n_req = '0;
        if (branch_id) begin
            // A load feeding the branch comparator dominates: LD_BR_STALLS >= 1
            if (w_ex_hit && memread_ex) begin
                n_req = c_ld_br;
            end else if (w_ex_hit || w_mem_hit) begin
                n_req = 2'd1;
            end
        end else if (w_ex_hit && memread_ex) begin
            n_req = 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_unit
// Description : ID-stage hazard stall sequencer with saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_AW       = DEF_REG_AW,
    parameter int LD_BR_STALLS = 2,
    parameter int CNT_W        = 16
) (
    input wire logic          clk,
    input wire logic          rst_n,
    hazard_ctrl_unit_if.slave hz
);

    hz_state_t        state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    stall_req_t       n_req;
    logic             stall;

    hazard_match #(
        .REG_AW       (REG_AW),
        .LD_BR_STALLS (LD_BR_STALLS)
    ) u_match (
        .rs_id       (hz.rs_id),
        .rt_id       (hz.rt_id),
        .use_rs_id   (hz.use_rs_id),
        .use_rt_id   (hz.use_rt_id),
        .branch_id   (hz.branch_id),
        .dst_ex      (hz.dst_ex),
        .regwrite_ex (hz.regwrite_ex),
        .memread_ex  (hz.memread_ex),
        .dst_mem     (hz.dst_mem),
        .memread_mem (hz.memread_mem),
        .n_req       (n_req)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HZ_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            HZ_IDLE: begin
                if (!hz.ext_stall && (n_req != 2'd0)) begin
                    stall = 1'b1;
                    if (n_req > 2'd1) begin
                        state_d = HZ_HOLD;
                        rem_d   = n_req - 2'd1;
                    end
                end
            end
            HZ_HOLD: begin
                // A frozen pipe keeps the hold state but does not consume it
                stall = 1'b1;
                if (!hz.ext_stall) begin
                    rem_d = rem_q - 2'd1;
                    if (rem_q <= 2'd1) begin
                        state_d = HZ_IDLE;
                        rem_d   = '0;
                    end
                end
            end
            default: begin
                state_d = HZ_IDLE;
                rem_d   = '0;
            end
        endcase
        if (stall && !hz.ext_stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        hz.pc_write     = 1'b1;
        hz.ifid_write   = 1'b1;
        hz.idex_noop    = 1'b0;
        hz.ifid_flush   = 1'b0;
        hz.stall_active = 1'b0;
        if (!rst_n) begin
            hz.pc_write = 1'b1;
        end else if (hz.ext_stall) begin
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.stall_active = stall;
        end else begin
            hz.pc_write     = !stall;
            hz.ifid_write   = !stall;
            hz.idex_noop    = stall;
            hz.stall_active = stall;
            hz.ifid_flush   = hz.branch_id && hz.branch_taken_id && !stall;
        end
    end

    assign hz.stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl_unit
// Description : Directed self-checking bench for hazard_ctrl_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 8;
    localparam int LD_BR  = 2;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    hazard_ctrl_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

    hazard_ctrl_unit #(
        .REG_AW       (REG_AW),
        .LD_BR_STALLS (LD_BR),
        .CNT_W        (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        assert (got === exp)
        else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // pc_write, ifid_write, idex_noop, ifid_flush, stall_active
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {28'd0, hz.pc_write, hz.ifid_write, hz.idex_noop, hz.ifid_flush, hz.stall_active},
            {27'd0, exp});
    endtask

    task automatic clr();
        hz.rs_id           = '0;
        hz.rt_id           = '0;
        hz.use_rs_id       = 1'b0;
        hz.use_rt_id       = 1'b0;
        hz.branch_id       = 1'b0;
        hz.branch_taken_id = 1'b0;
        hz.dst_ex          = '0;
        hz.regwrite_ex     = 1'b0;
        hz.memread_ex      = 1'b0;
        hz.dst_mem         = '0;
        hz.memread_mem     = 1'b0;
        hz.ext_stall       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Control patterns {pc_write, ifid_write, idex_noop, ifid_flush, stall_active}
    localparam logic [4:0] c_run    = 5'b11000;
    localparam logic [4:0] c_stall  = 5'b00101;
    localparam logic [4:0] c_flush  = 5'b11010;
    localparam logic [4:0] c_frz_h  = 5'b00001;
    localparam logic [4:0] c_frz_i  = 5'b00000;

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        clr();
        step();
        step();
        chk_ctl("reset_ctl", c_run);
        chk("reset_cnt", 32'(hz.stall_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        chk_ctl("idle_ctl", c_run);

        // load-use: lw $2 in EX, add reads $2
        hz.dst_ex = 5'd2; hz.regwrite_ex = 1'b1; hz.memread_ex = 1'b1;
        hz.rs_id = 5'd2; hz.use_rs_id = 1'b1;
        #1;
        chk_ctl("lu_stall", c_stall);
        step();
        clr();
        hz.rs_id = 5'd2; hz.use_rs_id = 1'b1;
        hz.dst_mem = 5'd2; hz.memread_mem = 1'b1;
        #1;
        chk_ctl("lu_release", c_run);
        chk("lu_cnt", 32'(hz.stall_cnt), 32'd1);
        step();

        // load-to-branch: beq reads $3 from lw in EX, taken
        clr();
        hz.branch_id = 1'b1; hz.branch_taken_id = 1'b1;
        hz.rt_id = 5'd3; hz.use_rt_id = 1'b1;
        hz.dst_ex = 5'd3; hz.regwrite_ex = 1'b1; hz.memread_ex = 1'b1;
        #1;
        chk_ctl("lb_stall1", c_stall);
        step();
        hz.dst_ex = 5'd0; hz.regwrite_ex = 1'b0; hz.memread_ex = 1'b0;
        hz.dst_mem = 5'd3; hz.memread_mem = 1'b1;
        #1;
        chk_ctl("lb_stall2", c_stall);
        step();
        hz.dst_mem = 5'd0; hz.memread_mem = 1'b0;
        #1;
        chk_ctl("lb_flush", c_flush);
        chk("lb_cnt", 32'(hz.stall_cnt), 32'd3);
        step();

        // register 0 never hazards; unused source ignored
        clr();
        hz.branch_id = 1'b1;
        hz.dst_ex = 5'd0; hz.regwrite_ex = 1'b1; hz.memread_ex = 1'b1;
        hz.rs_id = 5'd0; hz.use_rs_id = 1'b1;
        #1;
        chk_ctl("r0_nostall", c_run);
        hz.dst_ex = 5'd5; hz.rs_id = 5'd5; hz.use_rs_id = 1'b0;
        #1;
        chk_ctl("unused_nostall", c_run);
        step();

        // ALU-to-branch: one stall; same producer to non-branch: none
        clr();
        hz.dst_ex = 5'd4; hz.regwrite_ex = 1'b1;
        hz.branch_id = 1'b1; hz.rs_id = 5'd4; hz.use_rs_id = 1'b1;
        #1;
        chk_ctl("alu_br_stall", c_stall);
        step();
        hz.branch_id = 1'b0;
        #1;
        chk_ctl("alu_nb_nostall", c_run);
        chk("alu_cnt", 32'(hz.stall_cnt), 32'd4);
        step();

        // load in MEM feeding a branch: one stall
        clr();
        hz.branch_id = 1'b1; hz.rs_id = 5'd6; hz.use_rs_id = 1'b1;
        hz.dst_mem = 5'd6; hz.memread_mem = 1'b1;
        #1;
        chk_ctl("mem_br_stall", c_stall);
        step();
        hz.dst_mem = 5'd0; hz.memread_mem = 1'b0;
        #1;
        chk_ctl("mem_br_release", c_run);
        chk("mem_cnt", 32'(hz.stall_cnt), 32'd5);

        // ext_stall in IDLE suppresses detection
        hz.dst_mem = 5'd6; hz.memread_mem = 1'b1; hz.ext_stall = 1'b1;
        #1;
        chk_ctl("frz_idle", c_frz_i);
        step();
        chk("frz_idle_cnt", 32'(hz.stall_cnt), 32'd5);

        // both MEM (N=1) and EX-load (N=2) match: largest wins, then freeze HOLD
        clr();
        hz.branch_id = 1'b1; hz.branch_taken_id = 1'b1;
        hz.rs_id = 5'd6; hz.use_rs_id = 1'b1; hz.dst_mem = 5'd6; hz.memread_mem = 1'b1;
        hz.rt_id = 5'd7; hz.use_rt_id = 1'b1;
        hz.dst_ex = 5'd7; hz.regwrite_ex = 1'b1; hz.memread_ex = 1'b1;
        #1;
        chk_ctl("max_stall1", c_stall);
        step();
        hz.ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ctl("frz_hold", c_frz_h);
            chk("frz_hold_cnt", 32'(hz.stall_cnt), 32'd6);
            step();
        end
        hz.ext_stall = 1'b0;
        #1;
        chk_ctl("hold_resume", c_stall);
        step();
        clr();
        #1;
        chk_ctl("hold_done", c_run);
        chk("hold_cnt", 32'(hz.stall_cnt), 32'd7);

        // reset during HOLD
        hz.branch_id = 1'b1;
        hz.rt_id = 5'd3; hz.use_rt_id = 1'b1;
        hz.dst_ex = 5'd3; hz.regwrite_ex = 1'b1; hz.memread_ex = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        chk_ctl("rst_forced", c_run);
        step();
        rst_n = 1'b1;
        clr();
        #1;
        chk_ctl("rst_idle", c_run);
        chk("rst_cnt", 32'(hz.stall_cnt), 32'd0);

        // saturation: continuous load-use for more than 2^CNT_W cycles
        hz.dst_ex = 5'd2; hz.regwrite_ex = 1'b1; hz.memread_ex = 1'b1;
        hz.rs_id = 5'd2; hz.use_rs_id = 1'b1;
        repeat (254) step();
        chk("sat_pre", 32'(hz.stall_cnt), 32'd254);
        repeat (10) step();
        chk("sat_cnt", 32'(hz.stall_cnt), 32'd255);
        chk_ctl("sat_ctl", c_stall);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard detection and stall sequencer for the 5-stage pipeline; sits in ID and drives the PC, IF/ID and ID/EX control.
- Covers load-use, ALU-to-branch and load-to-branch hazards, which need 1 or 2 stall cycles.
- Honours register 0, qualifies hazards with MemRead/RegWrite, and generates the IF/ID flush on taken branches.
- Provides a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5, register address width.
- LD_BR_STALLS, 2, stall cycles for a branch in ID that consumes a load in EX (legal 1..3).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- rs_id  in  REG_AW  ID source register 1.
- rt_id  in  REG_AW  ID source register 2.
- use_rs_id  in  1  ID instruction reads rs.
- use_rt_id  in  1  ID instruction reads rt.
- branch_id  in  1  ID instruction is a branch resolved in ID.
- branch_taken_id  in  1  branch outcome from the ID comparator.
- dst_ex  in  REG_AW  EX destination register.
- regwrite_ex  in  1  EX writes the register file.
- memread_ex  in  1  EX is a load.
- dst_mem  in  REG_AW  MEM destination register.
- memread_mem  in  1  MEM is a load.
- ext_stall  in  1  whole-pipe freeze request (memory busy).
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- idex_noop  out  1  insert bubble into ID/EX.
- ifid_flush  out  1  squash IF/ID contents.
- stall_active  out  1  hazard stall in progress (this cycle).
- stall_cnt  out  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- Match rules:
  - match_ex(r) = (r == dst_ex) && (r != 0) && regwrite_ex.
  - match_mem(r) = (r == dst_mem) && (r != 0) && memread_mem.
  - A source counts only if its use_* bit is set.
- Required stall count N, evaluated combinationally in IDLE only:
  - Non-branch with match_ex and memread_ex: N = 1 (load-use).
  - Branch with match_ex and memread_ex: N = LD_BR_STALLS.
  - Branch with match_ex and not memread_ex: N = 1.
  - Branch with match_mem: N = 1.
  - Otherwise N = 0.
  - If more than one rule applies, take the largest N.
- FSM with states IDLE and HOLD, plus a remaining counter rem of width 2.
  - IDLE, N > 0: stall this cycle. Go to HOLD with rem = N-1 if N > 1, otherwise stay in IDLE.
  - HOLD: stall this cycle and ignore detection. Decrement rem. Return to IDLE when rem reaches 1 this cycle (rem == 1 means this is the last held cycle).
- Stall cycle outputs: pc_write=0, ifid_write=0, idex_noop=1, stall_active=1, ifid_flush=0.
- Non-stall cycle outputs: pc_write=1, ifid_write=1, idex_noop=0, stall_active=0.
- ifid_flush = branch_id && branch_taken_id && !stall && !ext_stall. A branch is never flushed while stalled; its outcome is invalid then.
- ext_stall=1 has priority over everything:
  - pc_write=0, ifid_write=0, idex_noop=0, ifid_flush=0.
  - FSM state, rem and stall_cnt hold.
  - stall_active reflects the held state.
  - Detection is suppressed.
- Combinational outputs track inputs in the same cycle. The FSM, rem and stall_cnt update on the rising clk edge.
- stall_cnt increments on every hazard stall cycle that is not frozen by ext_stall, and saturates at all-ones.
- Reset (rst_n=0 at a clk edge): state=IDLE, rem=0, stall_cnt=0. Reset aborts any in-progress HOLD.
- While rst_n is low, outputs are forced to pc_write=1, ifid_write=1, idex_noop=0, ifid_flush=0, stall_active=0.

Decomposition:
- Shared pipeline package holds:
  - hazard state enum (HZ_IDLE, HZ_HOLD).
  - REG_ZERO constant.
  - default REG_AW.
  - a typedef for the stall-count request.
- Natural sub-module: hazard_match. Purely combinational; computes N from the ID/EX/MEM fields. The top module holds the FSM, the output decode and the perf counter.

Test Plan:
- lw $2 in EX (memread_ex=1, regwrite_ex=1, dst_ex=2), add in ID with rs=2, use_rs=1 -> exactly 1 cycle of pc_write=0/idex_noop=1, then normal; stall_cnt=1.
- beq in ID with rt=3; lw dst_ex=3 in EX; LD_BR_STALLS=2 -> 2 consecutive stall cycles, no ifid_flush during them; taken branch flushes on cycle 3; stall_cnt=2.
- dst_ex=0 with regwrite_ex=1, rs_id=0, use_rs=1; then use_rs=0 with rs_id matching -> no stall in either case.
- ALU dst_ex=4 (memread_ex=0), beq rs=4 -> 1 stall. Same case with non-branch consumer -> 0 stalls.
- ext_stall=1 asserted mid-HOLD for 3 cycles -> all enables 0, idex_noop=0, rem/stall_cnt frozen; remaining stall completes after release.
- rst_n=0 during HOLD -> next cycle IDLE, stall_cnt=0. Separately, preload 2^CNT_W-1 stall cycles -> stall_cnt saturates and does not wrap.
